wr_pixel_packer: RTL and testbench



---
 rtl/wr_pixel_packer.sv | 132 +++++++++++++
 tb/tb_wr_pixel_packer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wr_pixel_packer.sv
// Packs PACK_N video pixels per FIFO word, flushing a zero-padded partial word at end of line.
// A one-word holding register absorbs FIFO back-pressure; words that cannot be held are counted as drops.
module wr_pixel_packer #(
    parameter int PIX_W  = 16,
    parameter int PACK_N = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vs_in,
    input  logic                    de_in,
    input  logic [PIX_W-1:0]        pix_in,
    output logic [PIX_W*PACK_N-1:0] fifo_wr_data,
    output logic                    fifo_wr_en,
    input  logic                    fifo_wr_vld,
    output logic                    frame_start,
    output logic [CNT_W-1:0]        ovf_cnt,
    output logic                    ovf_flag
);
    localparam int WORD_W = PIX_W * PACK_N;
    localparam int IDX_W  = $clog2(PACK_N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_N - 1);

    typedef enum logic [1:0] {S_WAIT_VS, S_ACTIVE, S_FLUSH} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [WORD_W-1:0]   acc, acc_nxt;
    logic [WORD_W-1:0]   lane_word;
    logic [WORD_W-1:0]   commit_word;
    logic                vs_prev, de_prev;
    logic                vs_rise, de_fall;
    logic                commit, accept, load, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        vs_rise = vs_in & ~vs_prev;
        de_fall = ~de_in & de_prev;
        accept  = fifo_wr_en & fifo_wr_vld;

        // acc keeps unwritten lanes at zero, so a flushed word is padded for free
        lane_word = acc;
        for (int k = 0; k < PACK_N; k++) begin
            if (idx == IDX_W'(k)) lane_word[k*PIX_W +: PIX_W] = pix_in;
        end

        state_nxt   = state;
        idx_nxt     = idx;
        acc_nxt     = acc;
        commit      = 1'b0;
        commit_word = acc;

        case (state)
            S_WAIT_VS: begin
                if (vs_rise) begin
                    idx_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    idx_nxt = '0;
                    acc_nxt = '0;
                end else if (de_in) begin
                    if (idx == IDX_LAST) begin
                        commit      = 1'b1;
                        commit_word = lane_word;
                        idx_nxt     = '0;
                        acc_nxt     = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                        acc_nxt = lane_word;
                    end
                end else if (de_fall && idx != '0) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                commit      = 1'b1;
                commit_word = acc;
                idx_nxt     = '0;
                acc_nxt     = '0;
                state_nxt   = S_ACTIVE;
            end
            default: state_nxt = S_WAIT_VS;
        endcase

        load = commit & (~fifo_wr_en | accept);
        drop = commit & ~load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_WAIT_VS;
            idx          <= '0;
            acc          <= '0;
            vs_prev      <= 1'b0;
            de_prev      <= 1'b0;
            frame_start  <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            ovf_cnt      <= '0;
            ovf_flag     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            acc         <= acc_nxt;
            vs_prev     <= vs_in;
            de_prev     <= de_in;
            frame_start <= vs_rise;

            // holding register: reload in the accept cycle gives back-to-back words
            if (load) begin
                fifo_wr_data <= commit_word;
                fifo_wr_en   <= 1'b1;
            end else if (accept) begin
                fifo_wr_en <= 1'b0;
            end

            if (drop) begin
                ovf_cnt  <= sat_inc(ovf_cnt);
                ovf_flag <= 1'b1;
            end else if (vs_rise) begin
                ovf_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wr_pixel_packer.sv
// Directed bench for wr_pixel_packer: a queue-based pixel/word model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wr_pixel_packer;
    localparam int PIX_W  = 16;
    localparam int PACK_N = 4;
    localparam int CNT_W  = 16;
    localparam int WORD_W = PIX_W * PACK_N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vs_in = 1'b0;
    logic              de_in = 1'b0;
    logic [PIX_W-1:0]  pix_in = '0;
    logic [WORD_W-1:0] fifo_wr_data;
    logic              fifo_wr_en;
    logic              fifo_wr_vld = 1'b1;
    logic              frame_start;
    logic [CNT_W-1:0]  ovf_cnt;
    logic              ovf_flag;

    int vectors = 0;
    int miscompares = 0;
    logic check_on = 1'b0;

    // model state
    int                m_mode = 0;  // 0 waiting for frame, 1 active, 2 flush pending
    logic [PIX_W-1:0]  lanes[$];
    logic              m_vs = 1'b0, m_de = 1'b0;
    logic              exp_en = 1'b0, exp_fs = 1'b0, exp_flag = 1'b0;
    logic [WORD_W-1:0] exp_data = '0;
    logic [CNT_W-1:0]  exp_cnt = '0;

    wr_pixel_packer #(.PIX_W(PIX_W), .PACK_N(PACK_N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_vld(fifo_wr_vld),
        .frame_start(frame_start), .ovf_cnt(ovf_cnt), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Applies the spec rules to the inputs sampled at this clock edge.
    task automatic model_step();
        logic rise, fall, acc, have, dropped;
        logic [WORD_W-1:0] w;
        if (!rst_n) begin
            m_mode = 0; lanes.delete(); m_vs = 0; m_de = 0;
            exp_en = 0; exp_data = '0; exp_fs = 0; exp_cnt = '0; exp_flag = 0;
        end else begin
            rise = vs_in && !m_vs;
            fall = !de_in && m_de;
            acc  = exp_en && fifo_wr_vld;
            have = 0; dropped = 0; w = '0;
            if (m_mode == 0) begin
                if (rise) begin lanes.delete(); m_mode = 1; end
            end else if (m_mode == 1) begin
                if (rise) lanes.delete();
                else if (de_in) begin
                    lanes.push_back(pix_in);
                    if (lanes.size() == PACK_N) have = 1;
                end else if (fall && lanes.size() > 0) m_mode = 2;
            end else begin
                have = 1; m_mode = 1;
            end
            if (have) begin
                for (int i = 0; i < lanes.size(); i++) w[i*PIX_W +: PIX_W] = lanes[i];
                lanes.delete();
            end
            exp_fs = rise;
            if (have && (!exp_en || acc)) begin
                exp_data = w; exp_en = 1;
            end else if (have) begin
                dropped = 1;
                if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1;
                exp_flag = 1;
            end else if (acc) exp_en = 0;
            if (!dropped && rise) exp_flag = 0;
            m_vs = vs_in; m_de = de_in;
        end
    endtask

    task automatic cyc(input logic vs, input logic de, input logic [PIX_W-1:0] pix);
        vs_in = vs; de_in = de; pix_in = pix;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("wr_en", fifo_wr_en, exp_en);
            chk("frame_start", frame_start, exp_fs);
            chk("ovf_cnt", ovf_cnt, exp_cnt);
            chk("ovf_flag", ovf_flag, exp_flag);
            if (exp_en) chk("wr_data", fifo_wr_data, exp_data);
        end
    end

    initial begin
        // reset
        rst_n = 0;
        cyc(0, 0, 0);
        check_on = 1;
        cyc(0, 0, 0);
        chk("rst_en", fifo_wr_en, 0);
        chk("rst_data", fifo_wr_data, 0);
        chk("rst_cnt", ovf_cnt, 0);
        rst_n = 1;
        cyc(0, 1, 16'h00AA);  // de ignored before first vs
        chk("wait_vs_no_write", fifo_wr_en, 0);

        // frame start and two full words
        cyc(1, 0, 0);
        chk("fs_pulse", frame_start, 1);
        cyc(0, 0, 0);
        chk("fs_single", frame_start, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 16'(i));
            if (i == 4) begin
                chk("word1_en", fifo_wr_en, 1);
                chk("word1", fifo_wr_data, 64'h0004_0003_0002_0001);
                chk("model_word1", exp_data, 64'h0004_0003_0002_0001);
            end
            if (i == 5) chk("word1_done", fifo_wr_en, 0);
            if (i == 8) chk("word2", fifo_wr_data, 64'h0008_0007_0006_0005);
        end
        cyc(0, 0, 0);
        chk("idle_en", fifo_wr_en, 0);
        chk("cnt_zero", ovf_cnt, 0);

        // 6-pixel line with flush
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 16'h0011 + 16'(i));
            if (i == 3) chk("line_w1", fifo_wr_data, 64'h0014_0013_0012_0011);
        end
        cyc(0, 0, 0);
        chk("flush_not_yet", fifo_wr_en, 0);
        cyc(0, 0, 0);
        chk("flush_en", fifo_wr_en, 1);
        chk("flush_word", fifo_wr_data, 64'h0000_0000_0016_0015);
        chk("model_flush", exp_data, 64'h0000_0000_0016_0015);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // back-pressure over a 12-pixel burst
        fifo_wr_vld = 0;
        for (int i = 0; i < 12; i++) cyc(0, 1, 16'h0021 + 16'(i));
        cyc(0, 0, 0);
        chk("bp_hold_en", fifo_wr_en, 1);
        chk("bp_hold_data", fifo_wr_data, 64'h0024_0023_0022_0021);
        chk("bp_cnt", ovf_cnt, 2);
        chk("bp_flag", ovf_flag, 1);
        fifo_wr_vld = 1;
        cyc(0, 0, 0);
        chk("bp_drain", fifo_wr_en, 0);
        cyc(0, 0, 0);

        // release exactly on the second commit: back-to-back, no drop
        fifo_wr_vld = 0;
        for (int i = 1; i <= 8; i++) begin
            fifo_wr_vld = (i == 8);
            cyc(0, 1, 16'h0030 + 16'(i));
        end
        chk("b2b_en", fifo_wr_en, 1);
        chk("b2b_data", fifo_wr_data, 64'h0038_0037_0036_0035);
        chk("b2b_cnt", ovf_cnt, 2);
        cyc(0, 0, 0);
        chk("b2b_drain", fifo_wr_en, 0);

        // vs edge mid-line discards the partial word
        for (int i = 1; i <= 3; i++) cyc(0, 1, 16'h0040 + 16'(i));
        cyc(1, 0, 0);
        chk("vs_fs", frame_start, 1);
        chk("vs_flag_clr", ovf_flag, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("vs_no_flush", fifo_wr_en, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'h0050 + 16'(i));
        chk("vs_clean_word", fifo_wr_data, 64'h0054_0053_0052_0051);
        cyc(0, 0, 0);

        // reset mid-line with a word pending
        fifo_wr_vld = 0;
        for (int i = 1; i <= 6; i++) cyc(0, 1, 16'h0060 + 16'(i));
        chk("pend_before_rst", fifo_wr_en, 1);
        rst_n = 0;
        cyc(0, 1, 16'h0067);
        chk("mrst_en", fifo_wr_en, 0);
        chk("mrst_data", fifo_wr_data, 0);
        chk("mrst_cnt", ovf_cnt, 0);
        chk("mrst_flag", ovf_flag, 0);
        rst_n = 1;
        fifo_wr_vld = 1;
        for (int i = 1; i <= 8; i++) cyc(0, 1, 16'h0070 + 16'(i));
        chk("post_rst_ignored", fifo_wr_en, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'h0080 + 16'(i));
        chk("post_rst_word", fifo_wr_data, 64'h0084_0083_0082_0081);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        check_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
